fact_core_seq: RTL and testbench

//  Iterative factorial engine computing n! for a 4-bit n on a one-cycle go pulse.

---
 rtl/fact_pkg.sv | 15 +
 rtl/fact_core_seq_if.sv | 34 +++
 rtl/fact_shift_mul.sv | 89 ++++++++
 rtl/fact_core_seq.sv | 122 ++++++++++++
 tb/tb_fact_core_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fact_pkg.sv
// Shared constants and state encoding for the iterative factorial engine.
package fact_pkg;

  localparam int FACT_MAX_N = 12;
  localparam int FACT_RES_W = 32;
  localparam int FACT_N_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } fact_state_e;

endpackage

// File: rtl/fact_core_seq_if.sv
// Handshake/status bundle between the MMIO register block and the factorial core.
// The register side (master) drives go/in; the core (slave) drives the status and result.
interface fact_core_seq_if;
  import fact_pkg::*;

  logic                  go;
  logic [FACT_N_W-1:0]   in;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [1:0]            cs;
  logic [FACT_RES_W-1:0] result;

  modport master (
    output go,
    output in,
    input  busy,
    input  done,
    input  error,
    input  cs,
    input  result
  );

  modport slave (
    input  go,
    input  in,
    output busy,
    output done,
    output error,
    output cs,
    output result
  );

endinterface

// File: rtl/fact_shift_mul.sv
// Shift-add multiplier used by fact_core_seq when FACT_SHIFT_MUL_EN is defined.
// Takes exactly NW cycles from start to ack: the start cycle handles bit 0 of b,
// each following cycle one more bit, and p carries the full product in the ack cycle.
module fact_shift_mul
  import fact_pkg::*;
#(
  parameter int RW = FACT_RES_W,
  parameter int NW = FACT_N_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] a,
  input  logic [NW-1:0] b,
  output logic          busy,
  output logic          ack,
  output logic [RW-1:0] p
);

  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  logic          busy_q, busy_d;
  logic [RW-1:0] a_q, a_d;
  logic [NW-1:0] b_q, b_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;

  logic          active;
  logic          last;
  logic [RW-1:0] a_cur;
  logic [NW-1:0] b_cur;
  logic [RW-1:0] acc_cur;
  logic [IW-1:0] idx_cur;
  logic [RW-1:0] partial;
  logic [RW-1:0] sum;

  // Operand/accumulator registers, cleared immediately on reset so an abort leaves nothing in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
    end else begin
      busy_q <= busy_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      idx_q  <= idx_d;
    end
  end

  // One partial product per cycle; operands come straight from the ports in the start cycle
  always_comb begin
    busy_d  = busy_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;

    active  = busy_q | start;
    a_cur   = busy_q ? a_q   : a;
    b_cur   = busy_q ? b_q   : b;
    acc_cur = busy_q ? acc_q : '0;
    idx_cur = busy_q ? idx_q : '0;

    partial = b_cur[idx_cur] ? (a_cur << idx_cur) : '0;
    sum     = acc_cur + partial;
    last    = (idx_cur == IW'(NW - 1));

    ack     = active & last;
    p       = sum;

    if (active && !last) begin
      busy_d = 1'b1;
      a_d    = a_cur;
      b_d    = b_cur;
      acc_d  = sum;
      idx_d  = idx_cur + IW'(1);
    end else if (active && last) begin
      busy_d = 1'b0;
      idx_d  = '0;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/fact_core_seq.sv
// Iterative factorial engine: computes n! for a 4-bit n after a one-cycle go pulse.
// Emits a one-cycle done pulse (result loaded) or a one-cycle error pulse (n > MAX_N).
// Optional macro FACT_SHIFT_MUL_EN: each multiply step runs on the NW-cycle shift-add
// multiplier instead of a single-cycle combinational multiply; results are identical.
module fact_core_seq
  import fact_pkg::*;
#(
  parameter int NW    = FACT_N_W,
  parameter int RW    = FACT_RES_W,
  parameter int MAX_N = FACT_MAX_N
) (
  input  logic         clk,
  input  logic         rst,
  fact_core_seq_if.slave bus
);

  fact_state_e   state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] product_q, product_d;
  logic [RW-1:0] result_q, result_d;

`ifdef FACT_SHIFT_MUL_EN
  logic          mul_start;
  logic          mul_busy;
  logic          mul_ack;
  logic [RW-1:0] mul_p;

  fact_shift_mul #(
    .RW (RW),
    .NW (NW)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (product_q),
    .b     (cnt_q),
    .busy  (mul_busy),
    .ack   (mul_ack),
    .p     (mul_p)
  );
`else
  logic [RW-1:0] cnt_ext;
  assign cnt_ext = RW'(cnt_q);
`endif

  // State, down-counter, running product and held result; reset aborts any operation at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      product_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      result_q  <= result_d;
    end
  end

  // Next-state logic: accept go only in IDLE, multiply down to cnt<=1, then pulse done or error
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    result_d  = result_q;
`ifdef FACT_SHIFT_MUL_EN
    mul_start = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.go) begin
          if (bus.in > NW'(MAX_N)) begin
            state_d = ERR;
          end else begin
            cnt_d     = bus.in;
            product_d = RW'(1);
            state_d   = MUL;
          end
        end
      end

      MUL: begin
        if (cnt_q <= NW'(1)) begin
          state_d = DONE;
        end else begin
`ifdef FACT_SHIFT_MUL_EN
          mul_start = !mul_busy;
          if (mul_ack) begin
            product_d = mul_p;
            cnt_d     = cnt_q - NW'(1);
          end
`else
          product_d = product_q * cnt_ext;
          cnt_d     = cnt_q - NW'(1);
`endif
        end
      end

      DONE: begin
        result_d = product_q;
        state_d  = IDLE;
      end

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.error  = (state_q == ERR);
  assign bus.cs     = state_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_fact_core_seq.sv
// Scoreboard bench for fact_core_seq: stimulus pushes expected responses (kind, cycle, value),
// a negedge monitor pops and checks them whenever done or error fires.
// Honours FACT_SHIFT_MUL_EN for the expected done latency.
module tb_fact_core_seq;

  typedef struct {
    bit          is_err;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cycle;
  int   compared;
  int   mismatched;

  exp_t        sb[$];
  exp_t        e;
  bit          pending;
  logic [31:0] pending_val;

  fact_core_seq_if bus ();

  fact_core_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: value seen at a negedge identifies the current clock cycle
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int expLat(input int n);
    int m;
    m = (n < 1) ? 1 : n;
`ifdef FACT_SHIFT_MUL_EN
    return 4 * (m - 1) + 2;
`else
    return m + 1;
`endif
  endfunction

  // Issue one go pulse and record what the monitor should later see
  task automatic applyStimulus(input logic [3:0] n, input bit is_err, input logic [31:0] exp_val);
    exp_t x;
    @(negedge clk);
    x.is_err = is_err;
    x.val    = exp_val;
    x.cyc    = cycle + (is_err ? 1 : expLat(int'(n)));
    sb.push_back(x);
    bus.go = 1'b1;
    bus.in = n;
    @(negedge clk);
    bus.go = 1'b0;
    bus.in = 4'($urandom);
  endtask

  task automatic waitIdle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !pending) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: timeout, %0d responses outstanding", name, sb.size());
      sb.delete();
      pending = 1'b0;
    end
  endtask

  task automatic waitDone(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: no done within bound", name);
    end
  endtask

  // Monitor: result one cycle after each pulse, pulse kind and cycle at the pulse itself
  always @(negedge clk) begin
    if (rst) begin
      if (pending) begin
        checkOutput("result", bus.result, pending_val);
        pending = 1'b0;
      end
      if (bus.done || bus.error) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_pulse: got done=%0b error=%0b, expected none", bus.done, bus.error);
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_kind_error", 32'(bus.error), 32'(e.is_err));
          checkOutput("pulse_cycle", 32'(cycle), 32'(e.cyc));
          pending     = 1'b1;
          pending_val = e.val;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cycle       = 0;
    compared    = 0;
    mismatched  = 0;
    pending     = 1'b0;
    pending_val = '0;
    rst         = 1'b0;
    bus.go      = 1'b0;
    bus.in      = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy",   32'(bus.busy),  32'd0);
    checkOutput("reset_done",   32'(bus.done),  32'd0);
    checkOutput("reset_error",  32'(bus.error), 32'd0);
    checkOutput("reset_cs",     32'(bus.cs),    32'd0);
    checkOutput("reset_result", bus.result,     32'd0);
    rst = 1'b1;

    $display("[TB] test 1: n=5");
    applyStimulus(4'd5, 1'b0, 32'd120);
    checkOutput("busy_while_mul", 32'(bus.busy), 32'd1);
    waitIdle("n5");

    $display("[TB] test 2: n=0 then n=1");
    applyStimulus(4'd0, 1'b0, 32'd1);
    waitIdle("n0");
    applyStimulus(4'd1, 1'b0, 32'd1);
    waitIdle("n1");

    $display("[TB] test 3: n=12 then n=13");
    applyStimulus(4'd12, 1'b0, 32'h1C8C_FC00);
    waitIdle("n12");
    applyStimulus(4'd13, 1'b1, 32'h1C8C_FC00);
    waitIdle("n13");
    applyStimulus(4'd15, 1'b1, 32'h1C8C_FC00);
    waitIdle("n15");

    $display("[TB] test 4: go while busy is ignored");
    applyStimulus(4'd7, 1'b0, 32'd5040);
    @(negedge clk);
    bus.go = 1'b1;
    bus.in = 4'd3;
    @(negedge clk);
    bus.go = 1'b0;
    waitIdle("n7");

    $display("[TB] test 5: reset mid-operation");
    applyStimulus(4'd9, 1'b0, 32'd362880);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    pending = 1'b0;
    #1;
    checkOutput("abort_busy",   32'(bus.busy), 32'd0);
    checkOutput("abort_result", bus.result,    32'd0);
    checkOutput("abort_cs",     32'(bus.cs),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(4'd4, 1'b0, 32'd24);
    waitIdle("n4_after_reset");

    $display("[TB] test 6: back-to-back");
    applyStimulus(4'd3, 1'b0, 32'd6);
    waitDone("b2b_first");
    applyStimulus(4'd4, 1'b0, 32'd24);
    waitIdle("b2b_second");

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
